// File: rtl/hist_stream_reader.sv
// hist_stream_reader
//   Receives one frame of NUM_BINS histogram bin counts from a byte-wide
//   stream, stores them in a local register file and accumulates summary
//   statistics while the frame arrives. Malformed frames are flagged.
//   The stored counts can be read back through a registered port.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   arm                   - one-cycle pulse: clear capture state, await frame
//   bin_data/valid/last   - incoming bin stream
//   busy, done            - frame in progress / frame complete
//   err_short/err_overrun - frame ended early / frame had too many bins
//   total, mode_bin, mode_count, nonzero_bins - frame statistics
//   rd_addr, rd_data      - readback of captured counts, 1-cycle latency
module hist_stream_reader #(
    parameter int NUM_BINS = 16,
    parameter int COUNT_W  = 8,
    parameter int IDX_W    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic [COUNT_W-1:0]       bin_data,
    input  logic                     bin_valid,
    input  logic                     bin_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err_short,
    output logic                     err_overrun,
    output logic [COUNT_W+IDX_W-1:0] total,
    output logic [IDX_W-1:0]         mode_bin,
    output logic [COUNT_W-1:0]       mode_count,
    output logic [IDX_W:0]           nonzero_bins,
    input  logic [IDX_W-1:0]         rd_addr,
    output logic [COUNT_W-1:0]       rd_data
);

    localparam int TOTAL_W = COUNT_W + IDX_W;
    localparam logic [IDX_W:0] FULL_IDX = (IDX_W+1)'(NUM_BINS);
    localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_BINS - 1);
    localparam logic [IDX_W:0] IDX_ONE  = (IDX_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RECEIVE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W:0]       idx_q, idx_d;
    logic [COUNT_W-1:0]   mem_q [NUM_BINS];
    logic [COUNT_W-1:0]   mem_d [NUM_BINS];
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic [IDX_W-1:0]     mode_bin_q, mode_bin_d;
    logic [COUNT_W-1:0]   mode_count_q, mode_count_d;
    logic [IDX_W:0]       nonzero_q, nonzero_d;
    logic                 err_short_q, err_short_d;
    logic                 err_overrun_q, err_overrun_d;
    logic [COUNT_W-1:0]   rd_data_q, rd_data_d;
    logic                 accept;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mem_d         = mem_q;
        total_d       = total_q;
        mode_bin_d    = mode_bin_q;
        mode_count_d  = mode_count_q;
        nonzero_d     = nonzero_q;
        err_short_d   = err_short_q;
        err_overrun_d = err_overrun_q;
        rd_data_d     = mem_q[rd_addr];
        accept        = bin_valid && ((state_q == S_ARMED) || (state_q == S_RECEIVE));

        // arm wins over a coincident beat; that beat is simply lost
        if (arm) begin
            state_d       = S_ARMED;
            idx_d         = '0;
            mem_d         = '{default: '0};
            total_d       = '0;
            mode_bin_d    = '0;
            mode_count_d  = '0;
            nonzero_d     = '0;
            err_short_d   = 1'b0;
            err_overrun_d = 1'b0;
        end else if (accept) begin
            if (idx_q < FULL_IDX) begin
                mem_d[idx_q[IDX_W-1:0]] = bin_data;
                idx_d   = idx_q + IDX_ONE;
                total_d = total_q + TOTAL_W'(bin_data);
                if (bin_data != '0) begin
                    nonzero_d = nonzero_q + IDX_ONE;
                end
                // strict compare: ties keep the earlier bin
                if (bin_data > mode_count_q) begin
                    mode_count_d = bin_data;
                    mode_bin_d   = idx_q[IDX_W-1:0];
                end
                if (bin_last && (idx_q < LAST_IDX)) begin
                    err_short_d = 1'b1;
                end
            end else begin
                // index saturates at NUM_BINS; extra data is discarded
                err_overrun_d = 1'b1;
            end
            state_d = bin_last ? S_DONE : S_RECEIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            mem_q         <= '{default: '0};
            total_q       <= '0;
            mode_bin_q    <= '0;
            mode_count_q  <= '0;
            nonzero_q     <= '0;
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mem_q         <= mem_d;
            total_q       <= total_d;
            mode_bin_q    <= mode_bin_d;
            mode_count_q  <= mode_count_d;
            nonzero_q     <= nonzero_d;
            err_short_q   <= err_short_d;
            err_overrun_q <= err_overrun_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign busy         = (state_q == S_ARMED) || (state_q == S_RECEIVE);
    assign done         = (state_q == S_DONE);
    assign err_short    = err_short_q;
    assign err_overrun  = err_overrun_q;
    assign total        = total_q;
    assign mode_bin     = mode_bin_q;
    assign mode_count   = mode_count_q;
    assign nonzero_bins = nonzero_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_hist_stream_reader.sv
// Testbench for hist_stream_reader: directed frames with a scoreboard of
// expected frame statistics and readback values.
module tb_hist_stream_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic [7:0]  bin_data;
    logic        bin_valid;
    logic        bin_last;
    logic        busy;
    logic        done;
    logic        err_short;
    logic        err_overrun;
    logic [11:0] total;
    logic [3:0]  mode_bin;
    logic [7:0]  mode_count;
    logic [4:0]  nonzero_bins;
    logic [3:0]  rd_addr;
    logic [7:0]  rd_data;

    hist_stream_reader #(
        .NUM_BINS(16),
        .COUNT_W (8),
        .IDX_W   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .bin_data    (bin_data),
        .bin_valid   (bin_valid),
        .bin_last    (bin_last),
        .busy        (busy),
        .done        (done),
        .err_short   (err_short),
        .err_overrun (err_overrun),
        .total       (total),
        .mode_bin    (mode_bin),
        .mode_count  (mode_count),
        .nonzero_bins(nonzero_bins),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int total;
        int mode_bin;
        int mode_count;
        int nonzero;
        int short_f;
        int over_f;
    } frame_exp_t;

    frame_exp_t exp_q[$];
    int         rd_q[$];
    int         beats[$];
    int         model_mem[16];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err_short"}, 32'(err_short), 0);
        check({tag, "_err_overrun"}, 32'(err_overrun), 0);
        check({tag, "_total"}, 32'(total), 0);
        check({tag, "_mode_bin"}, 32'(mode_bin), 0);
        check({tag, "_mode_count"}, 32'(mode_count), 0);
        check({tag, "_nonzero"}, 32'(nonzero_bins), 0);
    endtask

    // arm pulse, optionally with a coincident beat that must be dropped
    task automatic do_arm(input bit with_beat);
        @(negedge clk);
        arm       = 1'b1;
        bin_valid = with_beat;
        bin_data  = 8'd255;
        bin_last  = 1'b0;
        @(negedge clk);
        arm       = 1'b0;
        bin_valid = 1'b0;
    endtask

    // beats not tracked by the scoreboard (ignored or later aborted)
    task automatic send_raw(input int n, input int value, input bit last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bin_valid = 1'b1;
            bin_data  = 8'(value);
            bin_last  = last && (i == n - 1);
        end
        @(negedge clk);
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic rd_check(input int addr);
        @(negedge clk);
        rd_addr = 4'(addr);
        rd_q.push_back(model_mem[addr]);
        @(negedge clk);
        check($sformatf("rd_data[%0d]", addr), 32'(rd_data), rd_q.pop_front());
    endtask

    // streams the contents of beats[] as one frame (bin_last on final beat)
    task automatic run_frame(input string tag, input bit gaps);
        frame_exp_t e;
        int n;
        e = '{default: 0};
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        n = beats.size();
        for (int i = 0; i < n; i++) begin
            if (i < 16) begin
                model_mem[i] = beats[i];
                e.total += beats[i];
                if (beats[i] != 0) e.nonzero++;
                if (beats[i] > e.mode_count) begin
                    e.mode_count = beats[i];
                    e.mode_bin   = i;
                end
            end else begin
                e.over_f = 1;
            end
        end
        e.short_f = (n < 16) ? 1 : 0;
        exp_q.push_back(e);

        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bin_valid = 1'b1;
            bin_data  = 8'(beats[i]);
            bin_last  = (i == n - 1);
            if (gaps) begin
                @(negedge clk);
                bin_valid = 1'b0;
                bin_last  = 1'b0;
            end
        end
        @(negedge clk);
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        for (int k = 0; k < 20 && done !== 1'b1; k++) @(negedge clk);

        e = exp_q.pop_front();
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err_short"}, 32'(err_short), 32'(e.short_f));
        check({tag, "_err_overrun"}, 32'(err_overrun), 32'(e.over_f));
        check({tag, "_total"}, 32'(total), 32'(e.total));
        check({tag, "_mode_bin"}, 32'(mode_bin), 32'(e.mode_bin));
        check({tag, "_mode_count"}, 32'(mode_count), 32'(e.mode_count));
        check({tag, "_nonzero"}, 32'(nonzero_bins), 32'(e.nonzero));
    endtask

    initial begin
        reset     = 1'b1;
        arm       = 1'b0;
        bin_data  = '0;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        rd_addr   = '0;
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        check_all_zero("reset");
        check("reset_rd_data", 32'(rd_data), 0);

        // beats without arm are ignored
        send_raw(3, 55, 1'b1);
        check_all_zero("idle_beats");
        rd_check(0);

        // ramp frame 0..15
        do_arm(1'b0);
        check("armed_busy", 32'(busy), 1);
        beats = {};
        for (int i = 0; i < 16; i++) beats.push_back(i);
        run_frame("ramp", 1'b0);
        rd_check(7);
        rd_check(15);
        // beats in DONE change nothing
        send_raw(1, 99, 1'b1);
        check("done_hold_total", 32'(total), 120);
        check("done_hold_done", 32'(done), 1);
        rd_check(3);

        // gapped frame with a tie for the mode
        do_arm(1'b0);
        beats = {};
        for (int i = 0; i < 16; i++) beats.push_back((i == 3 || i == 9) ? 200 : 0);
        run_frame("gaps", 1'b1);
        rd_check(9);

        // short frame
        do_arm(1'b0);
        beats = {10, 10, 10, 10, 10};
        run_frame("short", 1'b0);
        rd_check(6);
        rd_check(4);

        // overrun frame
        do_arm(1'b0);
        beats = {};
        for (int i = 0; i < 18; i++) beats.push_back(1);
        run_frame("overrun", 1'b0);
        rd_check(15);

        // abort mid-RECEIVE; the beat coincident with arm is dropped
        do_arm(1'b0);
        send_raw(4, 255, 1'b0);
        check("abort_pre_total", 32'(total), 1020);
        do_arm(1'b1);
        check("abort_busy", 32'(busy), 1);
        check("abort_done", 32'(done), 0);
        check("abort_total", 32'(total), 0);
        check("abort_nonzero", 32'(nonzero_bins), 0);
        check("abort_mode_count", 32'(mode_count), 0);
        beats = {};
        for (int i = 0; i < 16; i++) beats.push_back(1);
        run_frame("after_abort", 1'b0);

        // reset during RECEIVE
        do_arm(1'b0);
        send_raw(8, 7, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("midreset");
        for (int i = 0; i < 16; i++) model_mem[i] = 0;
        for (int a = 0; a < 16; a++) rd_check(a);
        send_raw(16, 3, 1'b1);
        check_all_zero("post_reset_noarm");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
